// File: rtl/store_forward_buffer_if.sv
// Bus bundle for store_forward_buffer: store push, load lookup, cache drain and occupancy.
// The slave modport is the buffer side; the master modport is the memory-stage/cache side.
interface store_forward_buffer_if #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  st_valid;
  logic [ADDR_WIDTH-1:0] st_addr;
  logic [DATA_WIDTH-1:0] st_data;
  logic                  st_ready;
  logic                  ld_valid;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic                  ld_hit;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  drain_valid;
  logic [ADDR_WIDTH-1:0] drain_addr;
  logic [DATA_WIDTH-1:0] drain_data;
  logic                  drain_ready;
  logic [CNT_W-1:0]      count;
  logic                  empty;

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, drain_ready,
    output st_ready, ld_hit, ld_data, drain_valid, drain_addr, drain_data, count, empty
  );

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, drain_ready,
    input  st_ready, ld_hit, ld_data, drain_valid, drain_addr, drain_data, count, empty
  );
endinterface

// File: rtl/store_forward_buffer.sv
// Circular store buffer draining in order to the cache, with youngest-first load forwarding.
// Optional store coalescing into the youngest entry: define STORE_FORWARD_BUFFER_COALESCE_EN.
module store_forward_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  store_forward_buffer_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] addr [DEPTH];
  logic [DATA_WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0]      vld;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;

  logic                  full;
  logic                  is_empty;
  logic                  coalesce_hit;
  logic                  push_alloc;
  logic                  pop;
  logic                  fwd_match;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic [PTR_W-1:0]      fwd_idx;

  assign full     = (count == CNT_W'(DEPTH));
  assign is_empty = (count == '0);

`ifdef STORE_FORWARD_BUFFER_COALESCE_EN
  logic [PTR_W-1:0] youngest;
  assign youngest = tail - PTR_W'(1);
  // count>=2 keeps the coalesce target away from the head, which may be draining this cycle
  assign coalesce_hit = bus.st_valid && (count >= CNT_W'(2)) && vld[youngest] &&
                        (addr[youngest] == bus.st_addr);
`else
  assign coalesce_hit = 1'b0;
`endif

  // A pop never frees a slot for a same-cycle push, so drain_ready stays off this path
  assign bus.st_ready = !full || coalesce_hit;
  assign push_alloc   = bus.st_valid && !full && !coalesce_hit;
  assign pop          = !is_empty && bus.drain_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      vld   <= '0;
    end else begin
      if (pop) begin
        vld[head] <= 1'b0;
        head      <= head + PTR_W'(1);
      end
      if (push_alloc) begin
        vld[tail] <= 1'b1;
        tail      <= tail + PTR_W'(1);
      end
      case ({push_alloc, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload is not reset; every read of it is qualified by vld or count
  always_ff @(posedge clk) begin
    if (push_alloc) begin
      addr[tail] <= bus.st_addr;
      data[tail] <= bus.st_data;
    end
`ifdef STORE_FORWARD_BUFFER_COALESCE_EN
    else if (coalesce_hit) begin
      data[youngest] <= bus.st_data;
    end
`endif
  end

  // Walk oldest to youngest so the youngest match is the last one to assign
  always_comb begin
    fwd_match = 1'b0;
    fwd_data  = '0;
    fwd_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      fwd_idx = tail - PTR_W'(i + 1);
      if (vld[fwd_idx] && (addr[fwd_idx] == bus.ld_addr)) begin
        fwd_match = 1'b1;
        fwd_data  = data[fwd_idx];
      end
    end
  end

  assign bus.ld_hit      = bus.ld_valid && fwd_match;
  assign bus.ld_data     = bus.ld_hit ? fwd_data : '0;
  assign bus.drain_valid = !is_empty;
  assign bus.drain_addr  = is_empty ? '0 : addr[head];
  assign bus.drain_data  = is_empty ? '0 : data[head];
  assign bus.count       = count;
  assign bus.empty       = is_empty;
endmodule

// File: tb/tb_store_forward_buffer.sv
// Bench for store_forward_buffer: directed vector table, async reset sequence, optional
// coalescing sequence, then randomized traffic against a queue-based reference model.
module tb_store_forward_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 26;
  localparam int DW    = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  store_forward_buffer_if #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  store_forward_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned sv, sa, sd, lv, la, dr;
    int unsigned e_sr, e_hit, e_ld, e_da, e_dd, e_cnt;
  } vec_t;

  typedef struct {
    int unsigned a;
    int unsigned d;
  } ent_t;

  vec_t vecs[$];
  ent_t q[$];

  function automatic vec_t mk(int unsigned sv, int unsigned sa, int unsigned sd,
                              int unsigned lv, int unsigned la, int unsigned dr,
                              int unsigned e_sr, int unsigned e_hit, int unsigned e_ld,
                              int unsigned e_da, int unsigned e_dd, int unsigned e_cnt);
    vec_t v;
    v.sv = sv; v.sa = sa; v.sd = sd; v.lv = lv; v.la = la; v.dr = dr;
    v.e_sr = e_sr; v.e_hit = e_hit; v.e_ld = e_ld; v.e_da = e_da; v.e_dd = e_dd; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input int unsigned sv, input int unsigned sa, input int unsigned sd,
                        input int unsigned lv, input int unsigned la, input int unsigned dr);
    bus.st_valid    = 1'(sv);
    bus.st_addr     = AW'(sa);
    bus.st_data     = DW'(sd);
    bus.ld_valid    = 1'(lv);
    bus.ld_addr     = AW'(la);
    bus.drain_ready = 1'(dr);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    set_in(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    vec_t v;
    set_in(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;

    // Reset state, with a lookup presented
    #2;
    set_in(0, 0, 0, 1, 'h10, 1);
    #1;
    chk("rst st_ready", 64'(bus.st_ready), 64'd1);
    chk("rst drain_valid", 64'(bus.drain_valid), 64'd0);
    chk("rst empty", 64'(bus.empty), 64'd1);
    chk("rst count", 64'(bus.count), 64'd0);
    chk("rst ld_hit", 64'(bus.ld_hit), 64'd0);
    chk("rst ld_data", 64'(bus.ld_data), 64'd0);
    chk("rst drain_addr", 64'(bus.drain_addr), 64'd0);
    chk("rst drain_data", 64'(bus.drain_data), 64'd0);
    do_reset();

    //                sv  sa     sd     lv  la     dr | sr hit ld     da     dd     cnt
    // fill then drain
    vecs.push_back(mk(1, 'h10, 'hA0, 0, 'h00, 0,  1, 0, 'h00, 'h00, 'h00, 0));
    vecs.push_back(mk(1, 'h11, 'hA1, 1, 'h10, 0,  1, 1, 'hA0, 'h10, 'hA0, 1));
    vecs.push_back(mk(1, 'h12, 'hA2, 0, 'h00, 0,  1, 0, 'h00, 'h10, 'hA0, 2));
    vecs.push_back(mk(1, 'h13, 'hA3, 0, 'h00, 0,  1, 0, 'h00, 'h10, 'hA0, 3));
    vecs.push_back(mk(1, 'h14, 'hEE, 1, 'h13, 0,  0, 1, 'hA3, 'h10, 'hA0, 4));
    vecs.push_back(mk(0, 'h00, 'h00, 1, 'h10, 1,  0, 1, 'hA0, 'h10, 'hA0, 4));
    vecs.push_back(mk(0, 'h00, 'h00, 1, 'h10, 1,  1, 0, 'h00, 'h11, 'hA1, 3));
    vecs.push_back(mk(0, 'h00, 'h00, 0, 'h00, 1,  1, 0, 'h00, 'h12, 'hA2, 2));
    vecs.push_back(mk(0, 'h00, 'h00, 0, 'h00, 1,  1, 0, 'h00, 'h13, 'hA3, 1));
    vecs.push_back(mk(0, 'h00, 'h00, 0, 'h00, 0,  1, 0, 'h00, 'h00, 'h00, 0));
    // forwarding priority with a duplicate address
    vecs.push_back(mk(1, 'h20, 'h01, 0, 'h00, 0,  1, 0, 'h00, 'h00, 'h00, 0));
    vecs.push_back(mk(1, 'h21, 'h02, 0, 'h00, 0,  1, 0, 'h00, 'h20, 'h01, 1));
    vecs.push_back(mk(1, 'h20, 'h03, 0, 'h00, 0,  1, 0, 'h00, 'h20, 'h01, 2));
    vecs.push_back(mk(0, 'h00, 'h00, 1, 'h20, 0,  1, 1, 'h03, 'h20, 'h01, 3));
    vecs.push_back(mk(0, 'h00, 'h00, 1, 'h22, 0,  1, 0, 'h00, 'h20, 'h01, 3));
    vecs.push_back(mk(0, 'h00, 'h00, 1, 'h20, 1,  1, 1, 'h03, 'h20, 'h01, 3));
    vecs.push_back(mk(0, 'h00, 'h00, 1, 'h20, 1,  1, 1, 'h03, 'h21, 'h02, 2));
    vecs.push_back(mk(0, 'h00, 'h00, 1, 'h20, 1,  1, 1, 'h03, 'h20, 'h03, 1));
    vecs.push_back(mk(0, 'h00, 'h00, 1, 'h20, 0,  1, 0, 'h00, 'h00, 'h00, 0));
    // same-cycle visibility: push invisible, popping head still forwards
    vecs.push_back(mk(1, 'h30, 'h55, 1, 'h30, 0,  1, 0, 'h00, 'h00, 'h00, 0));
    vecs.push_back(mk(0, 'h00, 'h00, 1, 'h30, 1,  1, 1, 'h55, 'h30, 'h55, 1));
    vecs.push_back(mk(0, 'h00, 'h00, 1, 'h30, 0,  1, 0, 'h00, 'h00, 'h00, 0));
    // full with pop: store refused that cycle, accepted the next
    vecs.push_back(mk(1, 'h50, 'hB0, 0, 'h00, 0,  1, 0, 'h00, 'h00, 'h00, 0));
    vecs.push_back(mk(1, 'h51, 'hB1, 0, 'h00, 0,  1, 0, 'h00, 'h50, 'hB0, 1));
    vecs.push_back(mk(1, 'h52, 'hB2, 0, 'h00, 0,  1, 0, 'h00, 'h50, 'hB0, 2));
    vecs.push_back(mk(1, 'h53, 'hB3, 0, 'h00, 0,  1, 0, 'h00, 'h50, 'hB0, 3));
    vecs.push_back(mk(1, 'h60, 'hC0, 0, 'h00, 1,  0, 0, 'h00, 'h50, 'hB0, 4));
    vecs.push_back(mk(1, 'h60, 'hC0, 0, 'h00, 0,  1, 0, 'h00, 'h51, 'hB1, 3));
    vecs.push_back(mk(0, 'h00, 'h00, 1, 'h60, 0,  0, 1, 'hC0, 'h51, 'hB1, 4));
    vecs.push_back(mk(0, 'h00, 'h00, 0, 'h52, 1,  0, 0, 'h00, 'h51, 'hB1, 4));

    foreach (vecs[i]) begin
      v = vecs[i];
      set_in(v.sv, v.sa, v.sd, v.lv, v.la, v.dr);
      @(negedge clk);
      chk($sformatf("v%0d st_ready", i), 64'(bus.st_ready), 64'(v.e_sr));
      chk($sformatf("v%0d ld_hit", i), 64'(bus.ld_hit), 64'(v.e_hit));
      chk($sformatf("v%0d ld_data", i), 64'(bus.ld_data), 64'(v.e_ld));
      chk($sformatf("v%0d drain_valid", i), 64'(bus.drain_valid), 64'(v.e_cnt != 0));
      chk($sformatf("v%0d drain_addr", i), 64'(bus.drain_addr), 64'(v.e_da));
      chk($sformatf("v%0d drain_data", i), 64'(bus.drain_data), 64'(v.e_dd));
      chk($sformatf("v%0d count", i), 64'(bus.count), 64'(v.e_cnt));
      chk($sformatf("v%0d empty", i), 64'(bus.empty), 64'(v.e_cnt == 0));
      tick();
    end

    // Async reset mid-cycle with 3 entries (0x52, 0x53, 0x60) held and the head on offer
    set_in(0, 0, 0, 1, 'h52, 0);
    @(negedge clk);
    chk("arst pre drain_valid", 64'(bus.drain_valid), 64'd1);
    chk("arst pre count", 64'(bus.count), 64'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("arst drain_valid", 64'(bus.drain_valid), 64'd0);
    chk("arst empty", 64'(bus.empty), 64'd1);
    chk("arst count", 64'(bus.count), 64'd0);
    chk("arst st_ready", 64'(bus.st_ready), 64'd1);
    chk("arst ld_hit", 64'(bus.ld_hit), 64'd0);
    chk("arst drain_addr", 64'(bus.drain_addr), 64'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    bus.drain_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post-arst%0d drain_valid", i), 64'(bus.drain_valid), 64'd0);
      chk($sformatf("post-arst%0d count", i), 64'(bus.count), 64'd0);
      chk($sformatf("post-arst%0d ld_hit", i), 64'(bus.ld_hit), 64'd0);
    end
    do_reset();

`ifdef STORE_FORWARD_BUFFER_COALESCE_EN
    set_in(1, 'h40, 'h5, 0, 0, 0); tick();
    set_in(1, 'h41, 'h6, 0, 0, 0); tick();
    set_in(1, 'h41, 'h7, 0, 0, 0); tick();
    set_in(0, 0, 0, 1, 'h41, 0);
    @(negedge clk);
    chk("coal count", 64'(bus.count), 64'd2);
    chk("coal ld_hit", 64'(bus.ld_hit), 64'd1);
    chk("coal ld_data", 64'(bus.ld_data), 64'h7);
    tick();
    set_in(1, 'h42, 'h8, 0, 0, 0); tick();
    set_in(1, 'h43, 'h9, 0, 0, 0); tick();
    set_in(1, 'h43, 'hA, 0, 0, 0);
    @(negedge clk);
    chk("coal full count", 64'(bus.count), 64'd4);
    chk("coal full st_ready", 64'(bus.st_ready), 64'd1);
    tick();
    set_in(0, 0, 0, 1, 'h43, 0);
    @(negedge clk);
    chk("coal full count after", 64'(bus.count), 64'd4);
    chk("coal full ld_data", 64'(bus.ld_data), 64'hA);
    tick();
    do_reset();
`endif

    // Randomized traffic against a queue model
    q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int unsigned sv, sa, sd, lv, la, dr, dr_pct;
      bit co, acc, e_hit, dv;
      int unsigned e_ld;
      dr_pct = ((cyc / 250) % 2 == 1) ? 20 : 70;
      sv = ($urandom_range(0, 99) < 60) ? 1 : 0;
      sa = $urandom_range(0, 7);
      sd = $urandom;
      lv = ($urandom_range(0, 99) < 70) ? 1 : 0;
      la = $urandom_range(0, 7);
      dr = ($urandom_range(0, 99) < dr_pct) ? 1 : 0;
      set_in(sv, sa, sd, lv, la, dr);

      co = 1'b0;
`ifdef STORE_FORWARD_BUFFER_COALESCE_EN
      co = (sv == 1) && (q.size() >= 2) && (q[q.size()-1].a == sa);
`endif
      acc = (q.size() < DEPTH) || co;
      e_hit = 1'b0;
      e_ld = 0;
      if (lv == 1) begin
        for (int k = q.size() - 1; k >= 0; k--) begin
          if (q[k].a == la) begin
            e_hit = 1'b1;
            e_ld = q[k].d;
            break;
          end
        end
      end
      dv = (q.size() > 0);

      @(negedge clk);
      chk("rnd st_ready", 64'(bus.st_ready), 64'(acc));
      chk("rnd ld_hit", 64'(bus.ld_hit), 64'(e_hit));
      chk("rnd ld_data", 64'(bus.ld_data), 64'(e_ld));
      chk("rnd drain_valid", 64'(bus.drain_valid), 64'(dv));
      chk("rnd drain_addr", 64'(bus.drain_addr), dv ? 64'(q[0].a) : 64'd0);
      chk("rnd drain_data", 64'(bus.drain_data), dv ? 64'(q[0].d) : 64'd0);
      chk("rnd count", 64'(bus.count), 64'(q.size()));
      chk("rnd empty", 64'(bus.empty), 64'(q.size() == 0));
      tick();

      if (co) begin
        q[q.size()-1].d = sd;
      end else if ((sv == 1) && acc) begin
        ent_t e;
        e.a = sa;
        e.d = sd;
        q.push_back(e);
      end
      if (dv && (dr == 1)) void'(q.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, required completion before %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
